switch_debouncer: RTL

Conditions the raw slide-switch inputs before they reach the switch PIO's `in_port`, which is read over Avalon-MM. Each bit is synchronised into `clk` with a two-flop synchroniser. Each bit is then debounced with its own counter, so `sw_stable` changes only after an input has held a new level for a programmable number of cycles. The block also gives a one-cycle change strobe, for later use as a PIO edge-capture or IRQ source.

---
 rtl/switch_debouncer_pkg.sv | 21 ++
 rtl/switch_debouncer_if.sv | 58 +++++
 rtl/switch_debouncer_debounce_bit.sv | 91 +++++++++
 rtl/switch_debouncer.sv | 81 ++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer_pkg
// Description : Shared types and default parameters for the slide-switch
//               debouncer (per-bit state enum, default sizing constants).
// Revision    : 1.0 - initial release
// ============================================================================
package switch_debouncer_pkg;

  // Per-bit debounce state: waiting for a change, or timing a candidate level
  typedef enum logic [0:0] {
    DB_IDLE    = 1'b0,
    DB_PENDING = 1'b1
  } db_state_t;

  localparam int SW_WIDTH_DEF        = 10;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int DB_CNT_W_DEF        = 16;

endpackage : switch_debouncer_pkg
`default_nettype wire

// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer_if
// Description : Bundles the raw switch pins and the conditioned outputs.
//               The per-bit edge strobes sw_rise/sw_fall exist only when
//               SWITCH_DEBOUNCER_EDGE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH_DEF
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic             sw_changed;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
`endif

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  // Board side: drives the pins, consumes conditioned levels and strobes
  modport master (
    output sw_raw,
    input  sw_stable,
    input  sw_changed,
    input  sw_rise,
    input  sw_fall
  );

  // Debouncer side
  modport slave (
    input  sw_raw,
    output sw_stable,
    output sw_changed,
    output sw_rise,
    output sw_fall
  );
`else
  // Board side: drives the pins, consumes conditioned levels and strobe
  modport master (
    output sw_raw,
    input  sw_stable,
    input  sw_changed
  );

  // Debouncer side
  modport slave (
    input  sw_raw,
    output sw_stable,
    output sw_changed
  );
`endif

endinterface : switch_debouncer_if
`default_nettype wire

// File: rtl/switch_debouncer_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : One switch bit: two-flop synchroniser, saturating-free
//               counter and IDLE/PENDING FSM. 'update_o' is high in the cycle
//               before the edge on which 'stable_o' takes the new level.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = DB_CNT_W_DEF
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic raw_i,
  output logic      stable_o,
  output logic      update_o
);

  // Last count value before a candidate level is accepted
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic            stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  db_state_t       state_q;
  db_state_t       state_d;
  logic            update;

  // Synchroniser, counter, FSM state and accepted level registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= DB_IDLE;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // Next-state logic: any return to the old level restarts the count; the
  // level is accepted only if sync2 still differs on the terminal count
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update   = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (sync2_q != stable_q) begin
          state_d = DB_PENDING;
          cnt_d   = C_CNT_ONE;
        end
      end
      DB_PENDING: begin
        if (sync2_q == stable_q) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d  = DB_IDLE;
          cnt_d    = '0;
          stable_d = sync2_q;
          update   = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stable_o = stable_q;
  assign update_o = update;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Synchronises and debounces WIDTH slide switches for the PIO
//               in_port and produces a one-cycle 'any bit changed' strobe.
//               Define SWITCH_DEBOUNCER_EDGE_EN to add per-bit rise/fall
//               strobes (sw_rise/sw_fall).
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = DB_CNT_W_DEF
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  switch_debouncer_if.slave sw_if
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] update;
  logic             changed_d;
  logic             changed_q;

  // One independent debouncer per switch bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw_i    (sw_if.sw_raw[i]),
      .stable_o (stable[i]),
      .update_o (update[i])
    );
  end

  assign changed_d = |update;

  // Registered so the strobe lines up with the new sw_stable value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign sw_if.sw_stable  = stable;
  assign sw_if.sw_changed = changed_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // An updating bit always flips, so its old level gives the direction
  assign rise_d = update & ~stable;
  assign fall_d = update & stable;

  // Per-bit edge strobes, aligned with sw_stable like sw_changed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sw_if.sw_rise = rise_q;
  assign sw_if.sw_fall = fall_q;
`endif

endmodule : switch_debouncer
`default_nettype wire
